ps2_scan_controller: RTL and testbench

- Sequences raw PS/2 Set-2 scan-code bytes from the keyboard receive path into complete key events.
- Resolves E0 (extended), F0 (break) and E1 (pause) prefixes, and drops device status bytes.
- Buffers events in a first-word-fall-through FIFO read by the processor, and tracks shift, ctrl and caps-lock state.
- Sits between the PS/2 receive datapath (scan byte plus one-cycle ready strobe) and the processor I/O bus.

---
 rtl/ps2_scan_controller.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_scan_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_controller.sv
// PS/2 Set-2 scan-code sequencer: turns raw scan bytes into key events.
// It resolves E0/F0/E1 prefixes, drops device status bytes, queues events in a
// first-word-fall-through FIFO and tracks the shift, ctrl and caps-lock state.
module ps2_scan_controller #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               scan_code,
    input  logic                     scan_valid,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic [9:0]               event_data,
    output logic                     event_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     shift,
    output logic                     ctrl,
    output logic                     caps_lock
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StPause} state_e;

    state_e        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          emit;
    logic [9:0]    emit_data;
    logic          is_status;

    // Device replies (BAT, ACK, resend, echo, errors) are not key events
    assign is_status = scan_code inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    // Prefix decoder: next state, pause skip count, idle timeout and event emission
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        tmo_d     = tmo_q;
        emit      = 1'b0;
        emit_data = '0;
        if (scan_valid) begin
            tmo_d = '0;
            case (state_q)
                StIdle: begin
                    if (scan_code == 8'hE0) begin
                        state_d = StExt;
                    end else if (scan_code == 8'hF0) begin
                        state_d = StBrk;
                    end else if (scan_code == 8'hE1) begin
                        state_d = StPause;
                        skip_d  = 3'd7;
                    end else if (!is_status) begin
                        emit      = 1'b1;
                        emit_data = {2'b00, scan_code};
                    end
                end
                StExt: begin
                    if (scan_code == 8'hF0) begin
                        state_d = StExtBrk;
                    end else begin
                        emit      = 1'b1;
                        emit_data = {2'b01, scan_code};
                        state_d   = StIdle;
                    end
                end
                StBrk: begin
                    emit      = 1'b1;
                    emit_data = {2'b10, scan_code};
                    state_d   = StIdle;
                end
                StExtBrk: begin
                    emit      = 1'b1;
                    emit_data = {2'b11, scan_code};
                    state_d   = StIdle;
                end
                StPause: begin
                    // The 7 bytes after E1 are swallowed; the last one yields the pause key
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        emit      = 1'b1;
                        emit_data = 10'h177;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = StIdle;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // Decoder state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            skip_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
        end
    end

    logic lshift_q, rshift_q, lctrl_q, rctrl_q, caps_held_q, caps_q;

    // Modifier tracking follows every emitted event, whether or not the FIFO accepts it
    always_ff @(posedge clk) begin
        if (!reset) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            caps_held_q <= 1'b0;
            caps_q      <= 1'b0;
        end else if (emit) begin
            case (emit_data[8:0])
                9'h012: lshift_q <= !emit_data[9];
                9'h059: rshift_q <= !emit_data[9];
                9'h014: lctrl_q  <= !emit_data[9];
                9'h114: rctrl_q  <= !emit_data[9];
                9'h058: begin
                    caps_held_q <= !emit_data[9];
                    // Typematic repeats arrive while held and must not toggle
                    if (!emit_data[9] && !caps_held_q) begin
                        caps_q <= !caps_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign shift     = lshift_q | rshift_q;
    assign ctrl      = lctrl_q | rctrl_q;
    assign caps_lock = caps_q;

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          full, empty, do_pop, do_push, drop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal
    assign do_push = emit && (!full || do_pop);
    assign drop    = emit && full && !do_pop;

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem_q[wr_ptr_q] <= emit_data;
        end
    end

    assign event_valid = !empty;
    assign event_data  = empty ? 10'h000 : mem_q[rd_ptr_q];
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_scan_controller.sv
// Self-checking bench for ps2_scan_controller: a queue-based event model checked
// every cycle, plus directed sequences with literal expectations.
module tb_ps2_scan_controller;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [9:0] event_data;
    logic       event_valid;
    logic [$clog2(DEPTH):0] count;
    logic       overflow, shift, ctrl, caps_lock;

    int errors = 0;
    int checks = 0;

    ps2_scan_controller #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .rd_en      (rd_en),
        .clr_ovf    (clr_ovf),
        .event_data (event_data),
        .event_valid(event_valid),
        .count      (count),
        .overflow   (overflow),
        .shift      (shift),
        .ctrl       (ctrl),
        .caps_lock  (caps_lock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending prefix as flags, events as a queue, keys held as a set
    logic [9:0] mq[$];
    bit         m_ovf, m_caps, m_ext, m_brk, started;
    bit         held [512];
    int         m_pause, m_gap;

    always @(posedge clk) begin : model
        logic [9:0] ev;
        bit have, pop, full_before, ovf_set;
        started = 1'b1;
        if (!reset) begin
            mq.delete();
            m_ovf = 0; m_caps = 0; m_ext = 0; m_brk = 0; m_pause = 0; m_gap = 0;
            for (int i = 0; i < 512; i++) held[i] = 1'b0;
        end else begin
            have = 0;
            ev = '0;
            ovf_set = 0;
            pop = rd_en && (mq.size() > 0);
            full_before = (mq.size() == DEPTH);
            if (scan_valid) begin
                // A byte after a long silence starts afresh
                if ((m_ext || m_brk || m_pause > 0) && m_gap >= TMO) begin
                    m_ext = 0; m_brk = 0; m_pause = 0;
                end
                m_gap = 0;
                if (m_pause > 0) begin
                    m_pause--;
                    if (m_pause == 0) begin have = 1; ev = 10'h177; end
                end else if (!m_ext && !m_brk) begin
                    case (scan_code)
                        8'hE0: m_ext = 1;
                        8'hF0: m_brk = 1;
                        8'hE1: m_pause = 7;
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        default: begin have = 1; ev = {2'b00, scan_code}; end
                    endcase
                end else if (m_ext && !m_brk && scan_code == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    have = 1;
                    ev = {m_brk, m_ext, scan_code};
                    m_ext = 0; m_brk = 0;
                end
            end else if (m_ext || m_brk || m_pause > 0) begin
                m_gap++;
            end
            if (have) begin
                if (ev[8:0] == 9'h058 && !ev[9] && !held[9'h058]) m_caps = !m_caps;
                held[ev[8:0]] = !ev[9];
            end
            if (pop) void'(mq.pop_front());
            if (have) begin
                if (full_before && !pop) ovf_set = 1;
                else mq.push_back(ev);
            end
            if (ovf_set) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        if (started) begin
            chk("event_valid", event_valid, mq.size() > 0);
            chk("count", count, mq.size());
            chk("event_data", event_data, (mq.size() > 0) ? mq[0] : 10'h000);
            chk("overflow", overflow, m_ovf);
            chk("shift", shift, held[9'h012] || held[9'h059]);
            chk("ctrl", ctrl, held[9'h014] || held[9'h114]);
            chk("caps_lock", caps_lock, m_caps);
        end
    end

    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idle(3);
        chk("rst_valid", event_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_data", event_data, 10'h000);
        chk("rst_mods", {overflow, shift, ctrl, caps_lock}, 4'b0000);
        reset = 1'b1;

        // Single make
        send(8'h1C);
        chk("a_valid", event_valid, 1);
        chk("a_data", event_data, 10'h01C);
        chk("a_count", count, 1);
        pop_n(1);
        chk("a_popped", event_valid, 0);

        // Break, extended make, extended break
        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("seq_count", count, 3);
        chk("seq_ev0", event_data, 10'h21C);
        pop_n(1);
        chk("seq_ev1", event_data, 10'h175);
        pop_n(1);
        chk("seq_ev2", event_data, 10'h375);
        pop_n(1);
        chk("seq_empty", count, 0);

        // Modifiers, drained continuously
        rd_en = 1'b1;
        send(8'h12);
        chk("shift_make", shift, 1);
        send(8'h58);
        chk("caps_on", caps_lock, 1);
        send(8'h58); send(8'h58);
        chk("caps_repeat", caps_lock, 1);
        send(8'hF0); send(8'h58);
        chk("caps_break", caps_lock, 1);
        send(8'hF0); send(8'h12);
        chk("shift_break", shift, 0);
        send(8'h14);
        send(8'hE0); send(8'h14);
        send(8'hF0); send(8'h14);
        chk("ctrl_right_held", ctrl, 1);
        send(8'hE0); send(8'hF0); send(8'h14);
        chk("ctrl_released", ctrl, 0);
        idle(1);
        rd_en = 1'b0;
        chk("mods_drained", count, 0);

        // Overflow and full push+pop
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        chk("full_count", count, DEPTH);
        chk("full_ovf", overflow, 1);
        chk("full_head", event_data, 10'h015);
        rd_en = 1'b1;
        send(8'h35);
        rd_en = 1'b0;
        chk("pushpop_count", count, DEPTH);
        chk("pushpop_head", event_data, 10'h01D);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);
        clr_ovf = 1'b1;
        send(8'h3C);
        clr_ovf = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        chk("ovf_head", event_data, 10'h01D);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        pop_n(DEPTH);
        chk("ovf_drained", count, 0);

        // Pause sequence and status bytes
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("pause_count", count, 1);
        chk("pause_data", event_data, 10'h177);
        chk("pause_ctrl", ctrl, 0);
        pop_n(1);
        send(8'hAA); send(8'hFA);
        chk("status_drop", count, 0);

        // Timeout abandons the prefix; a short gap does not
        send(8'hE0);
        idle(TMO);
        send(8'h1C);
        chk("timeout_data", event_data, 10'h01C);
        pop_n(1);
        send(8'hE0);
        idle(5);
        send(8'h75);
        chk("no_timeout_data", event_data, 10'h175);
        pop_n(1);

        // Reset mid-sequence
        send(8'h1C);
        send(8'hF0);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk("rst_mid_count", count, 0);
        send(8'h1C);
        chk("rst_mid_data", event_data, 10'h01C);
        chk("rst_mid_cnt1", count, 1);
        pop_n(1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
